// File: rtl/pc_redirect_pkg.sv
// Shared constants for the PC redirect controller: opcode map, flag bit positions
// and ras_err bit positions.
package pc_redirect_pkg;

  localparam int unsigned OpW = 5;

  localparam logic [OpW-1:0] OpJmp  = 5'h01;
  localparam logic [OpW-1:0] OpJz   = 5'h02;
  localparam logic [OpW-1:0] OpJnz  = 5'h03;
  localparam logic [OpW-1:0] OpJc   = 5'h04;
  localparam logic [OpW-1:0] OpJnc  = 5'h05;
  localparam logic [OpW-1:0] OpJv   = 5'h06;
  localparam logic [OpW-1:0] OpCall = 5'h07;
  localparam logic [OpW-1:0] OpRet  = 5'h08;
  localparam logic [OpW-1:0] OpReti = 5'h09;
  localparam logic [OpW-1:0] OpEi   = 5'h0A;
  localparam logic [OpW-1:0] OpDi   = 5'h0B;

  // flag_ex layout is {V,S,Z,C}
  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagS = 2;
  localparam int unsigned FlagV = 3;

  localparam int unsigned RasErrOvf = 0;
  localparam int unsigned RasErrUnf = 1;

endpackage

// File: rtl/pc_redirect_ctrl_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry; a pop
// when empty yields address 0. Both cases raise a one-cycle error pulse.
module ras_stack #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_W-1:0]            push_data_i,
  output logic [ADDR_W-1:0]            pop_data_o,
  output logic [$clog2(RAS_DEPTH):0]   depth_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]   sp_q, sp_d, top_idx;
  logic [PtrW:0]     depth_q, depth_d;

  // sp_q is the next free slot; when full it points at the oldest entry
  assign top_idx     = sp_q - 1'b1;
  assign pop_data_o  = (depth_q == '0) ? '0 : mem_q[top_idx];
  assign depth_o     = depth_q;
  assign overflow_o  = push_i && (depth_q == Full);
  assign underflow_o = pop_i && (depth_q == '0);

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (push_i) begin
      sp_d = sp_q + 1'b1;
      if (depth_q != Full) depth_d = depth_q + 1'b1;
    end else if (pop_i && (depth_q != '0)) begin
      sp_d    = top_idx;
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !reset_i) mem_q[sp_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Jump-control stage: opcode decode, branch conditions, vectored maskable interrupts,
// return-address stack and post-redirect shadow, driving a registered PC redirect.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INS_W      = 24,
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned VEC_BASE   = 32'hF0,
  parameter int unsigned VEC_STRIDE = 2,
  parameter int unsigned SHADOW     = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [INS_W-1:0]   ins_i,
  input  logic [ADDR_W-1:0]  current_address_i,
  input  logic [3:0]         flag_ex_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic [ADDR_W-1:0]  jmp_loc_o,
  output logic               pc_mux_sel_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               ie_o,
  output logic [1:0]         ras_err_o
);
  localparam int unsigned IdxW = 3;

  logic [OpW-1:0]             opcode;
  logic [ADDR_W-1:0]          ins_target, target, vec_addr, push_data, pop_data;
  logic [NUM_IRQ-1:0]         rise, pend_eff, cand, ack_oh;
  logic [IdxW-1:0]            irq_idx;
  logic                       free, take, redirect, push, pop, ras_ovf, ras_unf;
  logic [$clog2(RAS_DEPTH):0] ras_depth;
  logic                       unused_sig;

  logic [ADDR_W-1:0]  jmp_loc_q, jmp_loc_d;
  logic               pc_mux_sel_q, pc_mux_sel_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d, pend_q, pend_d, irq_prev_q;
  logic               ie_q, ie_d;
  logic [1:0]         ras_err_q, ras_err_d, shadow_q, shadow_d;

  assign opcode     = ins_i[INS_W-1 -: OpW];
  assign ins_target = ins_i[ADDR_W-1:0];
  assign unused_sig = ^{ins_i, flag_ex_i, ras_depth};

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .pop_data_o  (pop_data),
    .depth_o     (ras_depth),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_unf)
  );

  always_comb begin
    rise     = irq_i & ~irq_prev_q;
    pend_eff = pend_q | rise;
    cand     = pend_eff & irq_mask_i;
    free     = (shadow_q == 2'd0);
    irq_idx  = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) irq_idx = IdxW'(i);
    end
    take     = free && ie_q && (|cand);
    ack_oh   = take ? (NUM_IRQ'(1) << irq_idx) : '0;
    vec_addr = ADDR_W'(VEC_BASE + VEC_STRIDE * 32'(irq_idx));

    redirect  = 1'b0;
    target    = ins_target;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = current_address_i + 1'b1;
    ie_d      = ie_q;
    // An interrupt squashes the decode instruction, so it is re-executed on return
    if (take) begin
      push      = 1'b1;
      push_data = current_address_i;
      target    = vec_addr;
      redirect  = 1'b1;
      ie_d      = 1'b0;
    end else if (free) begin
      case (opcode)
        OpJmp:  redirect = 1'b1;
        OpJz:   redirect = flag_ex_i[FlagZ];
        OpJnz:  redirect = !flag_ex_i[FlagZ];
        OpJc:   redirect = flag_ex_i[FlagC];
        OpJnc:  redirect = !flag_ex_i[FlagC];
        OpJv:   redirect = flag_ex_i[FlagV];
        OpCall: begin
          push     = 1'b1;
          redirect = 1'b1;
        end
        OpRet: begin
          pop      = 1'b1;
          target   = pop_data;
          redirect = 1'b1;
        end
        OpReti: begin
          pop      = 1'b1;
          target   = pop_data;
          redirect = 1'b1;
          ie_d     = 1'b1;
        end
        OpEi:   ie_d = 1'b1;
        OpDi:   ie_d = 1'b0;
        default: ;
      endcase
    end

    jmp_loc_d    = redirect ? target : jmp_loc_q;
    pc_mux_sel_d = redirect;
    irq_ack_d    = ack_oh;
    pend_d       = pend_eff & ~ack_oh;
    shadow_d     = redirect ? 2'(SHADOW) : (free ? 2'd0 : shadow_q - 2'd1);
    ras_err_d    = ras_err_q;
    ras_err_d[RasErrOvf] = ras_err_q[RasErrOvf] | ras_ovf;
    ras_err_d[RasErrUnf] = ras_err_q[RasErrUnf] | ras_unf;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      jmp_loc_q    <= '0;
      pc_mux_sel_q <= 1'b0;
      irq_ack_q    <= '0;
      ie_q         <= 1'b0;
      ras_err_q    <= '0;
      pend_q       <= '0;
      shadow_q     <= 2'd0;
      irq_prev_q   <= irq_i;
    end else begin
      jmp_loc_q    <= jmp_loc_d;
      pc_mux_sel_q <= pc_mux_sel_d;
      irq_ack_q    <= irq_ack_d;
      ie_q         <= ie_d;
      ras_err_q    <= ras_err_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      irq_prev_q   <= irq_i;
    end
  end

  assign jmp_loc_o    = jmp_loc_q;
  assign pc_mux_sel_o = pc_mux_sel_q;
  assign irq_ack_o    = irq_ack_q;
  assign ie_o         = ie_q;
  assign ras_err_o    = ras_err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench: every issued cycle pushes the reference model's expected outputs;
// a negedge monitor pops and compares against what the DUT presents.
module tb_pc_redirect_ctrl;
  import pc_redirect_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 24;
  localparam int unsigned NI = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned VB = 32'hF0;
  localparam int unsigned VS = 2;
  localparam int unsigned SH = 1;
  localparam logic [4:0]  Nop = 5'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] ins;
  logic [AW-1:0] cur_addr;
  logic [3:0]    flag_ex, irq, irq_mask;
  logic [AW-1:0] jmp_loc;
  logic          pc_mux_sel, ie;
  logic [NI-1:0] irq_ack;
  logic [1:0]    ras_err;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .ADDR_W     (AW),
    .INS_W      (IW),
    .NUM_IRQ    (NI),
    .RAS_DEPTH  (RD),
    .VEC_BASE   (VB),
    .VEC_STRIDE (VS),
    .SHADOW     (SH)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .ins_i             (ins),
    .current_address_i (cur_addr),
    .flag_ex_i         (flag_ex),
    .irq_i             (irq),
    .irq_mask_i        (irq_mask),
    .jmp_loc_o         (jmp_loc),
    .pc_mux_sel_o      (pc_mux_sel),
    .irq_ack_o         (irq_ack),
    .ie_o              (ie),
    .ras_err_o         (ras_err)
  );

  typedef struct packed {
    logic       ie;
    logic [1:0] err;
    logic       sel;
    logic [3:0] ack;
    logic [7:0] jmp;
  } status_t;

  status_t st_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_ras[$];
  bit         m_ie;
  logic [1:0] m_err;
  logic [3:0] m_pend, m_prev;
  int         m_blocked;
  logic [7:0] m_jmp;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void ras_push(logic [7:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > RD) begin
      void'(m_ras.pop_front());
      m_err[0] = 1'b1;
    end
  endfunction

  function automatic logic [7:0] ras_pop();
    if (m_ras.size() == 0) begin
      m_err[1] = 1'b1;
      return 8'h00;
    end
    return m_ras.pop_back();
  endfunction

  task automatic model_step(input bit r, input logic [IW-1:0] in_w, input logic [7:0] addr,
                            input logic [3:0] fl, input logic [3:0] irqv, input logic [3:0] msk);
    status_t    e;
    logic [4:0] op;
    logic [7:0] tgt;
    logic [3:0] cand;
    bit         redir, free;
    op    = in_w[IW-1 -: 5];
    tgt   = in_w[7:0];
    e.ack = '0;
    redir = 1'b0;
    if (r) begin
      m_ras.delete();
      m_ie = 1'b0; m_err = '0; m_pend = '0; m_prev = irqv; m_blocked = 0; m_jmp = '0;
    end else begin
      m_pend = m_pend | (irqv & ~m_prev);
      m_prev = irqv;
      cand   = m_pend & msk;
      free   = (m_blocked == 0);
      if (!free) m_blocked--;
      if (free && m_ie && cand != 0) begin
        for (int i = 0; i < int'(NI); i++) begin
          if (cand[i]) begin
            e.ack[i]  = 1'b1;
            m_pend[i] = 1'b0;
            tgt       = 8'(VB + VS * i);
            break;
          end
        end
        ras_push(addr);
        m_ie  = 1'b0;
        redir = 1'b1;
      end else if (free) begin
        case (op)
          OpJmp:  redir = 1'b1;
          OpJz:   redir = fl[FlagZ];
          OpJnz:  redir = !fl[FlagZ];
          OpJc:   redir = fl[FlagC];
          OpJnc:  redir = !fl[FlagC];
          OpJv:   redir = fl[FlagV];
          OpCall: begin ras_push(addr + 8'd1); redir = 1'b1; end
          OpRet:  begin tgt = ras_pop(); redir = 1'b1; end
          OpReti: begin tgt = ras_pop(); redir = 1'b1; m_ie = 1'b1; end
          OpEi:   m_ie = 1'b1;
          OpDi:   m_ie = 1'b0;
          default: ;
        endcase
      end
      if (redir) begin
        m_jmp     = tgt;
        m_blocked = SH;
      end
    end
    e.ie  = m_ie;
    e.err = m_err;
    e.sel = redir;
    e.jmp = m_jmp;
    st_q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [4:0] op, input logic [7:0] tgt,
                      input logic [7:0] addr, input logic [3:0] fl);
    reset    = r;
    ins      = {op, 11'($urandom), tgt};
    cur_addr = addr;
    flag_ex  = fl;
    model_step(r, ins, addr, fl, irq, irq_mask);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    status_t e;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("pc_mux_sel", int'(pc_mux_sel), int'(e.sel));
      chk("jmp_loc", int'(jmp_loc), int'(e.jmp));
      chk("irq_ack", int'(irq_ack), int'(e.ack));
      chk("ie", int'(ie), int'(e.ie));
      chk("ras_err", int'(ras_err), int'(e.err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [11];
    ops = '{OpJmp, OpJz, OpJnz, OpJc, OpJnc, OpJv, OpCall, OpRet, OpReti, OpEi, OpDi};
    irq      = 4'h0;
    irq_mask = 4'hF;

    step(1, Nop, 8'h00, 8'h00, 4'h0);
    step(1, Nop, 8'h00, 8'h00, 4'h0);
    chk("reset_sel", int'(pc_mux_sel), 0);
    chk("reset_jmp", int'(jmp_loc), 0);

    // Conditional jump taken and not taken
    step(0, OpJz, 8'h40, 8'h10, 4'b0010);
    chk("jz_taken_sel", int'(pc_mux_sel), 1);
    chk("jz_taken_jmp", int'(jmp_loc), 'h40);
    step(0, Nop, 8'h00, 8'h11, 4'h0);
    step(0, OpJz, 8'h40, 8'h12, 4'b0000);
    chk("jz_not_taken_sel", int'(pc_mux_sel), 0);

    // Call / return
    step(0, OpCall, 8'h80, 8'h20, 4'h0);
    chk("call_jmp", int'(jmp_loc), 'h80);
    step(0, Nop, 8'h00, 8'h80, 4'h0);
    step(0, OpRet, 8'h00, 8'h30, 4'h0);
    chk("ret_jmp", int'(jmp_loc), 'h21);
    chk("ret_ras_err", int'(ras_err), 0);
    step(0, Nop, 8'h00, 8'h21, 4'h0);

    // Two simultaneous interrupt edges, served lowest first
    step(0, OpEi, 8'h00, 8'h32, 4'h0);
    irq = 4'b0110;
    step(0, Nop, 8'h00, 8'h33, 4'h0);
    chk("irq1_ack", int'(irq_ack), 'b0010);
    chk("irq1_jmp", int'(jmp_loc), 'hF2);
    chk("irq1_ie", int'(ie), 0);
    step(0, Nop, 8'h00, 8'hF2, 4'h0);
    step(0, OpReti, 8'h00, 8'hF3, 4'h0);
    chk("reti_jmp", int'(jmp_loc), 'h33);
    chk("reti_ie", int'(ie), 1);
    step(0, Nop, 8'h00, 8'h33, 4'h0);
    step(0, Nop, 8'h00, 8'h34, 4'h0);
    chk("irq2_ack", int'(irq_ack), 'b0100);
    chk("irq2_jmp", int'(jmp_loc), 'hF4);
    step(0, Nop, 8'h00, 8'hF4, 4'h0);
    irq = 4'h0;

    // Interrupt beats a same-cycle JMP
    step(0, OpEi, 8'h00, 8'hF5, 4'h0);
    step(0, Nop, 8'h00, 8'hF6, 4'h0);
    irq = 4'b0001;
    step(0, OpJmp, 8'h55, 8'h44, 4'h0);
    chk("irq0_over_jmp_jmp", int'(jmp_loc), 'hF0);
    chk("irq0_over_jmp_ack", int'(irq_ack), 'b0001);
    step(0, Nop, 8'h00, 8'hF0, 4'h0);
    step(0, OpReti, 8'h00, 8'hF1, 4'h0);
    chk("irq0_return_jmp", int'(jmp_loc), 'h44);
    step(0, Nop, 8'h00, 8'h44, 4'h0);
    irq = 4'h0;

    // Stack overflow then underflow
    step(1, Nop, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, OpCall, 8'(8'h80 + i), 8'(8'h60 + i), 4'h0);
      step(0, Nop, 8'h00, 8'h00, 4'h0);
    end
    chk("ras_overflow", int'(ras_err), 'b01);
    for (int i = 0; i < 5; i++) begin
      step(0, OpRet, 8'h00, 8'(8'h70 + i), 4'h0);
      chk("ras_pop_value", int'(jmp_loc), (i < 4) ? ('h65 - i) : 0);
      step(0, Nop, 8'h00, 8'h00, 4'h0);
    end
    chk("ras_underflow", int'(ras_err), 'b11);

    // Reset during the shadow of a taken jump, with irq held high through reset
    step(0, OpJmp, 8'h77, 8'h12, 4'h0);
    irq = 4'b0001;
    step(1, Nop, 8'h00, 8'h77, 4'h0);
    chk("mid_shadow_reset_sel", int'(pc_mux_sel), 0);
    chk("mid_shadow_reset_jmp", int'(jmp_loc), 0);
    chk("mid_shadow_reset_err", int'(ras_err), 0);
    step(1, Nop, 8'h00, 8'h00, 4'h0);
    step(0, OpEi, 8'h00, 8'h01, 4'h0);
    for (int i = 0; i < 4; i++) step(0, Nop, 8'h00, 8'(8'h02 + i), 4'h0);
    chk("held_irq_no_ack", int'(irq_ack), 0);
    chk("held_irq_ie", int'(ie), 1);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] op;
      int         s;
      s  = int'($urandom_range(0, 13));
      op = (s < 11) ? ops[s] : 5'($urandom_range(12, 31));
      if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) irq_mask = 4'($urandom);
      step($urandom_range(0, 99) == 0, op, 8'($urandom), 8'($urandom), 4'($urandom));
    end

    chk("scoreboard_drained", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
